uart_tx_frame_builder: RTL and testbench

//   Transmit-side counterpart of the UART receive byte analyser.

---
 rtl/uart_tx_frame_builder_pkg.sv | 21 ++
 rtl/uart_tx_frame_builder_if.sv | 11 +
 rtl/uart_tx_frame_builder_bit_timer.sv | 36 +++
 rtl/uart_tx_frame_builder.sv | 133 +++++++++++++
 tb/tb_uart_tx_frame_builder.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_frame_builder_pkg.sv
// rtl/uart_tx_frame_builder_pkg.sv - state encodings and defaults shared by the UART TX/RX byte paths
package uart_tx_frame_builder_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  // Encoding is shared with the RX-side analyser so State_o decodes the same way on both sides.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } tx_state_e;

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_frame_builder_if.sv
// rtl/uart_tx_frame_builder_if.sv - TX FIFO read port: active-low read strobe, next-clk data, empty flag
interface uart_tx_frame_builder_if;

  logic       n_re;
  logic [7:0] data;
  logic       p_empty;

  modport master (output n_re, input data, input p_empty);
  modport slave  (input n_re, output data, output p_empty);

endinterface

// File: rtl/uart_tx_frame_builder_bit_timer.sv
// rtl/uart_tx_frame_builder_bit_timer.sv - baud tick counter with a one-clk strobe on the last tick of a bit
module uart_tx_frame_builder_bit_timer #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic p_BaudTick_i,
  input  logic clear_i,
  output logic p_BitEnd_o
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (p_BaudTick_i) begin
      cnt_d = (cnt_q == LAST_TICK) ? 4'd0 : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign p_BitEnd_o = p_BaudTick_i && !clear_i && (cnt_q == LAST_TICK);

endmodule

// File: rtl/uart_tx_frame_builder.sv
// rtl/uart_tx_frame_builder.sv - pops TX FIFO bytes and serialises start, 8 data, optional parity, stop
module uart_tx_frame_builder
  import uart_tx_frame_builder_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_frame_builder_if.master  fifo,
  input  logic                     p_BaudTick_i,
  input  logic                     p_ParityEnable_i,
  input  logic                     p_ParityOdd_i,
  input  logic                     p_BigEnd_i,
  output logic                     txd_o,
  output logic                     p_Busy_o,
  output logic                     p_FrameDone_o,
  output logic [2:0]               State_o
);

  tx_state_e  state_q;
  logic       n_re_q;
  logic       txd_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] shift_q;
  logic [7:0] shift_d;
  logic [2:0] bit_idx_q;
  logic       par_en_q;
  logic       big_q;
  logic       par_q;
  logic       started_q;
  logic       next_bit;
  logic       bit_end;
  logic       timer_clear;

  // The start bit is anchored to the first baud tick after LOAD, so the timer is held clear until then.
  assign timer_clear = (state_q == ST_IDLE) || (state_q == ST_FETCH) || (state_q == ST_LOAD) ||
                       ((state_q == ST_START) && !started_q);

  uart_tx_frame_builder_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
    .clk          (clk),
    .rst          (rst),
    .p_BaudTick_i (p_BaudTick_i),
    .clear_i      (timer_clear),
    .p_BitEnd_o   (bit_end)
  );

  assign next_bit = big_q ? shift_q[7] : shift_q[0];
  assign shift_d  = big_q ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      n_re_q    <= 1'b1;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      par_en_q  <= 1'b0;
      big_q     <= 1'b0;
      par_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      n_re_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!fifo.p_empty) begin
            n_re_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: state_q <= ST_LOAD;
        ST_LOAD: begin
          shift_q   <= fifo.data;
          par_en_q  <= p_ParityEnable_i;
          big_q     <= p_BigEnd_i;
          par_q     <= parity_bit(fifo.data, p_ParityOdd_i);
          bit_idx_q <= '0;
          started_q <= 1'b0;
          state_q   <= ST_START;
        end
        ST_START: begin
          if (!started_q) begin
            if (p_BaudTick_i) begin
              txd_q     <= 1'b0;
              started_q <= 1'b1;
            end
          end else if (bit_end) begin
            txd_q   <= next_bit;
            shift_q <= shift_d;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              txd_q   <= par_en_q ? par_q : 1'b1;
              state_q <= par_en_q ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= next_bit;
              shift_q   <= shift_d;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            txd_q   <= 1'b1;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo.n_re     = n_re_q;
  assign txd_o         = txd_q;
  assign p_Busy_o      = busy_q;
  assign p_FrameDone_o = done_q;
  assign State_o       = state_q;

endmodule

// File: tb/tb_uart_tx_frame_builder.sv
// tb/tb_uart_tx_frame_builder.sv - scoreboard bench: expected frames queued at push, serial monitor compares
module tb_uart_tx_frame_builder;

  localparam int OS      = 16;
  localparam int TICKDIV = 3;
  localparam int BUDGET  = 4000;

  typedef struct {
    logic [10:0] bits;
    int          len;
  } frame_t;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       tick = 1'b0;
  logic       pe   = 1'b0;
  logic       odd  = 1'b0;
  logic       big  = 1'b0;
  logic       txd;
  logic       busy;
  logic       done;
  logic [2:0] st;

  uart_tx_frame_builder_if fifo ();

  uart_tx_frame_builder #(.OVERSAMPLE(OS)) dut (
    .clk              (clk),
    .rst              (rst),
    .fifo             (fifo),
    .p_BaudTick_i     (tick),
    .p_ParityEnable_i (pe),
    .p_ParityOdd_i    (odd),
    .p_BigEnd_i       (big),
    .txd_o            (txd),
    .p_Busy_o         (busy),
    .p_FrameDone_o    (done),
    .State_o          (st)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: start 0, data in chosen order, optional parity making the 1-count even/odd, stop 1.
  function automatic frame_t model(input logic [7:0] d, input logic pe_i, input logic odd_i,
                                   input logic big_i);
    frame_t f;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1 + i] = big_i ? d[7 - i] : d[i];
    if (pe_i) begin
      f.bits[9] = (($countones(d) % 2) == 1) ^ odd_i;
      f.len     = 11;
    end else begin
      f.len = 10;
    end
    return f;
  endfunction

  int div = 0;
  always @(posedge clk) begin
    tick <= (div == TICKDIV - 1);
    div  <= (div == TICKDIV - 1) ? 0 : div + 1;
  end

  logic [7:0] fifo_q[$];
  frame_t     exp_q[$];
  int         n_pops   = 0;
  int         n_pushed = 0;

  always @(posedge clk) begin
    if (rst) begin
      fifo.data <= 8'h00;
    end else if (fifo.n_re === 1'b0) begin
      check("fifo_read_only_when_nonempty", 32'(fifo_q.size() != 0), 32'd1);
      if (fifo_q.size() != 0) begin
        fifo.data <= fifo_q.pop_front();
        n_pops++;
      end
    end
    fifo.p_empty <= (fifo_q.size() == 0);
  end

  frame_t     cur;
  bit         mon_active   = 1'b0;
  bit         done_pending = 1'b0;
  bit         gap_armed    = 1'b0;
  bit         bit_bad      = 1'b0;
  int         mon_idx      = 0;
  int         mon_ticks    = 0;
  int         gap_cnt      = 0;
  int         done_cnt     = 0;
  int         frame_no     = 0;
  logic [4:0] bad_act;
  logic [4:0] exp_word;
  logic [2:0] exp_state;

  always @(negedge clk) begin
    if (rst) begin
      mon_active   = 1'b0;
      done_pending = 1'b0;
      gap_armed    = 1'b0;
    end else begin
      if (gap_armed) gap_cnt++;
      if (done_pending || done) check("frame_done_pulse", 32'(done), 32'(done_pending));
      done_pending = 1'b0;
      if (done) begin
        done_cnt++;
        if (!fifo.p_empty) begin
          gap_armed = 1'b1;
          gap_cnt   = 0;
        end
      end
      if (!mon_active && txd === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_start_bit: got txd=0, required idle line with no frame queued");
        end else begin
          cur        = exp_q.pop_front();
          mon_active = 1'b1;
          mon_idx    = 0;
          mon_ticks  = 0;
          bit_bad    = 1'b0;
          frame_no++;
          if (gap_armed) begin
            check("back_to_back_gap_clks", 32'(gap_cnt), (gap_cnt >= 4 && gap_cnt <= 3 + TICKDIV) ?
                  32'(gap_cnt) : 32'(3 + TICKDIV));
            gap_armed = 1'b0;
          end
        end
      end
      if (gap_armed && gap_cnt > 3 + TICKDIV) begin
        check("back_to_back_start_seen", 32'd0, 32'd1);
        gap_armed = 1'b0;
      end
      if (mon_active) begin
        if (mon_idx == 0) exp_state = 3'd3;
        else if (mon_idx <= 8) exp_state = 3'd4;
        else if (mon_idx == cur.len - 1) exp_state = 3'd6;
        else exp_state = 3'd5;
        exp_word = {exp_state, 1'b1, cur.bits[mon_idx]};
        if (!bit_bad && {st, busy, txd} !== exp_word) begin
          bit_bad = 1'b1;
          bad_act = {st, busy, txd};
        end
        if (tick) begin
          mon_ticks++;
          if (mon_ticks == OS) begin
            check($sformatf("frame%0d_bit%0d_state_busy_txd", frame_no, mon_idx),
                  32'(bit_bad ? bad_act : exp_word), 32'(exp_word));
            mon_idx++;
            mon_ticks = 0;
            bit_bad   = 1'b0;
            if (mon_idx == cur.len) begin
              mon_active   = 1'b0;
              done_pending = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(model(d, pe, odd, big));
    n_pushed++;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (t < BUDGET && !(exp_q.size() == 0 && fifo_q.size() == 0 && !mon_active &&
                           !done_pending && !busy)) begin
      step();
      t++;
    end
    check("idle_reached_within_budget", 32'(t < BUDGET), 32'd1);
    repeat (4) step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_txd"}, 32'(txd), 32'd1);
    check({tag, "_n_re"}, 32'(fifo.n_re), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(done), 32'd0);
    check({tag, "_state"}, 32'(st), 32'd0);
  endtask

  initial begin
    int d0;
    int p0;
    int t;
    int k;
    bit bad_nre;
    bit bad_txd;
    bit bad_busy;

    rst = 1'b1;
    repeat (3) step();
    check_reset_values("reset");
    rst = 1'b0;
    step();

    pe = 1'b0; odd = 1'b0; big = 1'b0;
    send(8'hA5);
    wait_idle();
    pe = 1'b1; odd = 1'b0; big = 1'b1;
    send(8'hA5);
    wait_idle();
    odd = 1'b1;
    send(8'hA5);
    wait_idle();

    pe = 1'b0; odd = 1'b0; big = 1'b0;
    d0 = done_cnt;
    p0 = n_pops;
    send(8'h00);
    send(8'hFF);
    wait_idle();
    check("b2b_frame_done_count", 32'(done_cnt - d0), 32'd2);
    check("b2b_read_count", 32'(n_pops - p0), 32'd2);

    bad_nre = 1'b0; bad_txd = 1'b0; bad_busy = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      pe  = 1'($urandom_range(0, 1));
      odd = 1'($urandom_range(0, 1));
      big = 1'($urandom_range(0, 1));
      step();
      if (fifo.n_re !== 1'b1) bad_nre = 1'b1;
      if (txd !== 1'b1) bad_txd = 1'b1;
      if (busy !== 1'b0) bad_busy = 1'b1;
    end
    check("empty_hold_n_re_high", 32'(!bad_nre), 32'd1);
    check("empty_hold_txd_high", 32'(!bad_txd), 32'd1);
    check("empty_hold_busy_low", 32'(!bad_busy), 32'd1);

    for (int it = 0; it < 24; it++) begin
      pe  = 1'($urandom_range(0, 1));
      odd = 1'($urandom_range(0, 1));
      big = 1'($urandom_range(0, 1));
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) send(8'($urandom_range(0, 255)));
      if (k == 1) begin
        t = 0;
        while (t < BUDGET && !mon_active) begin
          step();
          t++;
        end
        pe  = ~pe;
        odd = 1'($urandom_range(0, 1));
        big = ~big;
      end
      wait_idle();
    end

    pe = 1'b1; odd = 1'b0; big = 1'b0;
    send(8'h3C);
    t = 0;
    while (t < BUDGET && !(mon_active && mon_idx == 4)) begin
      step();
      t++;
    end
    check("reached_data_bit3", 32'(t < BUDGET), 32'd1);
    rst = 1'b1;
    d0 = done_cnt;
    step();
    check_reset_values("midframe_reset");
    rst = 1'b0;
    repeat (40) step();
    check("no_frame_done_after_reset", 32'(done_cnt - d0), 32'd0);
    check("line_idle_after_reset", 32'(txd), 32'd1);
    pe = 1'b0; big = 1'b1;
    send(8'h96);
    wait_idle();

    check("total_frame_done_count", 32'(done_cnt), 32'(n_pushed - 1));
    check("total_fifo_reads", 32'(n_pops), 32'(n_pushed));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
